seq_divider32: RTL

//  Multicycle restoring divider for the MIPS datapath: the inverse operation of the registered
//  32-bit adder, serving DIV/DIVU. Computes quotient (LO) and remainder (HI) by one

---
 rtl/seq_divider32.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_divider32.sv
`default_nettype none
// ============================================================================
// seq_divider32 : multicycle restoring divider (DIV/DIVU), one quotient bit
//                 per clock, fixed WIDTH+2 cycle latency.  Rev 1.0
// ============================================================================
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dvz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dvz_out;

  logic             w_dd_neg;
  logic             w_dv_neg;
  logic [WIDTH-1:0] w_dd_abs;
  logic [WIDTH-1:0] w_dv_abs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic             w_borrow;
  logic             w_ge;

  assign w_dd_neg = is_signed & dividend[WIDTH-1];
  assign w_dv_neg = is_signed & divisor[WIDTH-1];
  assign w_dd_abs = w_dd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dv_abs = w_dv_neg ? (~divisor + 1'b1) : divisor;

  // Top bit of the shifted partial remainder is the carry out; when set the
  // trial subtract always succeeds and its low WIDTH bits are still exact.
  assign w_shift             = {r_rem, r_quo[WIDTH-1]};
  assign {w_borrow, w_sub}   = {1'b0, w_shift[WIDTH-1:0]} - {1'b0, r_dvsr};
  assign w_ge                = w_shift[WIDTH] | ~w_borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dvz     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_q_out   <= '0;
      r_r_out   <= '0;
      r_dvz_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvsr  <= w_dv_abs;
            r_quo   <= w_dd_abs;
            r_rem   <= '0;
            r_cnt   <= CW'(WIDTH - 1);
            r_qneg  <= w_dd_neg ^ w_dv_neg;
            r_rneg  <= w_dd_neg;
            r_dvz   <= (divisor == '0);
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_q_out   <= r_qneg ? (~r_quo + 1'b1) : r_quo;
          r_r_out   <= r_rneg ? (~r_rem + 1'b1) : r_rem;
          r_dvz_out <= r_dvz;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign div_by_zero = r_dvz_out;

endmodule
`default_nettype wire
